// File: rtl/pll_lock_supervisor_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | pll_lock_supervisor_pkg: shared state encodings and sizing helper  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pll_lock_supervisor_pkg;

  localparam logic [2:0] ST_PLL_RST   = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_RELEASE   = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_bit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_bit: STAGES-deep synchronizer, async active-high reset to 0   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | pll_lock_supervisor: PLL reset/lock qualification, staged resets   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pll_lock_supervisor
  import pll_lock_supervisor_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 500000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int NUM_RST        = 4,
  parameter int RST_GAP        = 8,
  parameter int CNT_W          = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               locked_in,
  input  logic               soft_rst_req,
  output logic               pll_rst,
  output logic [NUM_RST-1:0] sys_rst,
  output logic               ready,
  output logic [CNT_W-1:0]   lock_lost_cnt,
  output logic [CNT_W-1:0]   retry_cnt,
  output logic               timeout_err,
  output logic [2:0]         state_dbg
);

  localparam int TMR_MAX = max_of(max_of(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                  max_of(STABLE_CYCLES, RST_GAP));
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int IDX_W   = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

  localparam logic [TMR_W-1:0] c_pll_last    = TMR_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] c_timeout_last = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] c_stable_last = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] c_gap_last    = TMR_W'(RST_GAP - 1);
  localparam logic [IDX_W-1:0] c_idx_last    = IDX_W'(NUM_RST - 1);

  logic [2:0]         r_state;
  logic [TMR_W-1:0]   r_timer;
  logic [IDX_W-1:0]   r_idx;
  logic               r_pll_rst;
  logic [NUM_RST-1:0] r_sys_rst;
  logic               r_ready;
  logic [CNT_W-1:0]   r_lost;
  logic [CNT_W-1:0]   r_retry;
  logic               r_timeout_err;
  logic               w_locked_s;
  logic               w_lock_loss;
  logic               w_timeout;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_locked (
    .clk (clk),
    .rst (rst),
    .d   (locked_in),
    .q   (w_locked_s)
  );

  assign w_lock_loss = ((r_state == ST_RELEASE) || (r_state == ST_RUN)) && !w_locked_s;
  assign w_timeout   = (r_state == ST_WAIT_LOCK) && (r_timer == c_timeout_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_PLL_RST;
      r_timer       <= '0;
      r_idx         <= '0;
      r_pll_rst     <= 1'b1;
      r_sys_rst     <= '1;
      r_ready       <= 1'b0;
      r_lost        <= '0;
      r_retry       <= '0;
      r_timeout_err <= 1'b0;
    end else if (w_lock_loss || w_timeout || soft_rst_req) begin
      // Every abort path lands in PLL_RST with a fresh pulse and all domains held.
      r_state   <= ST_PLL_RST;
      r_timer   <= '0;
      r_pll_rst <= 1'b1;
      r_sys_rst <= '1;
      r_ready   <= 1'b0;
      if (w_lock_loss) begin
        if (r_lost != '1) r_lost <= r_lost + 1'b1;
      end else if (w_timeout) begin
        if (r_retry != '1) r_retry <= r_retry + 1'b1;
        r_timeout_err <= 1'b1;
      end
    end else begin
      case (r_state)
        ST_PLL_RST: begin
          if (r_timer == c_pll_last) begin
            r_state   <= ST_WAIT_LOCK;
            r_timer   <= '0;
            r_pll_rst <= 1'b0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (w_locked_s) begin
            r_state <= ST_STABLE;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_STABLE: begin
          if (!w_locked_s) begin
            r_state <= ST_WAIT_LOCK;
            r_timer <= '0;
          end else if (r_timer == c_stable_last) begin
            r_timer      <= '0;
            r_idx        <= IDX_W'(1);
            r_sys_rst[0] <= 1'b0;
            if (NUM_RST == 1) begin
              r_state <= ST_RUN;
              r_ready <= 1'b1;
            end else begin
              r_state <= ST_RELEASE;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (r_timer == c_gap_last) begin
            r_timer          <= '0;
            r_sys_rst[r_idx] <= 1'b0;
            if (r_idx == c_idx_last) begin
              r_state <= ST_RUN;
              r_ready <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_RUN: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state   <= ST_PLL_RST;
          r_timer   <= '0;
          r_pll_rst <= 1'b1;
          r_sys_rst <= '1;
          r_ready   <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst       = r_pll_rst;
  assign sys_rst       = r_sys_rst;
  assign ready         = r_ready;
  assign lock_lost_cnt = r_lost;
  assign retry_cnt     = r_retry;
  assign timeout_err   = r_timeout_err;
  assign state_dbg     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pll_lock_supervisor: directed self-checking bench               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  logic       rst;
  logic       locked_in;
  logic       soft_rst_req;
  logic       pll_rst;
  logic [2:0] sys_rst;
  logic       ready;
  logic [7:0] lock_lost_cnt;
  logic [7:0] retry_cnt;
  logic       timeout_err;
  logic [2:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  pll_lock_supervisor #(
    .SYNC_STAGES    (2),
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (50),
    .STABLE_CYCLES  (8),
    .NUM_RST        (3),
    .RST_GAP        (2),
    .CNT_W          (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .locked_in     (locked_in),
    .soft_rst_req  (soft_rst_req),
    .pll_rst       (pll_rst),
    .sys_rst       (sys_rst),
    .ready         (ready),
    .lock_lost_cnt (lock_lost_cnt),
    .retry_cnt     (retry_cnt),
    .timeout_err   (timeout_err),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at cycle 0: reset just released, no edge since.
  task automatic do_reset();
    rst          = 1'b1;
    locked_in    = 1'b0;
    soft_rst_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (!ready && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL wait_ready: ready=%b after %0d cycles, required 1", ready, n);
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    locked_in    = 1'b0;
    soft_rst_req = 1'b0;
    tick();
    tick();
    checks++;
    if ({pll_rst, sys_rst, ready, timeout_err} !== 6'b1_111_0_0) begin
      failures++;
      $display("FAIL reset_outputs: got %b required 111100", {pll_rst, sys_rst, ready, timeout_err});
    end
    checks++;
    if ({lock_lost_cnt, retry_cnt} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_counters: got %h required 0000", {lock_lost_cnt, retry_cnt});
    end
    checks++;
    if (state_dbg !== 3'd0) begin
      failures++;
      $display("FAIL reset_state: got %0d required 0", state_dbg);
    end
  endtask

  task automatic test_nominal();
    logic [4:0] exp;
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      if (c == 10) locked_in = 1'b1;
      exp[4]   = (c <= 3);
      exp[3:1] = (c < 21) ? 3'b111 : (c < 23) ? 3'b110 : (c < 25) ? 3'b100 : 3'b000;
      exp[0]   = (c >= 25);
      checks++;
      if ({pll_rst, sys_rst, ready} !== exp) begin
        failures++;
        $display("FAIL nominal c=%0d: pll/sys/ready=%b required %b", c, {pll_rst, sys_rst, ready}, exp);
      end
      tick();
    end
    checks++;
    if (retry_cnt !== 8'd0 || state_dbg !== 3'd4) begin
      failures++;
      $display("FAIL nominal_end: retry=%0d state=%0d required 0/4", retry_cnt, state_dbg);
    end
  endtask

  task automatic test_glitch();
    logic [2:0] exp_st;
    logic [2:0] exp_sys;
    do_reset();
    for (int c = 0; c <= 34; c++) begin
      if (c == 10) locked_in = 1'b1;
      if (c == 15) locked_in = 1'b0;
      if (c == 18) locked_in = 1'b1;
      exp_st  = (c < 4) ? 3'd0 : (c < 13) ? 3'd1 : (c < 18) ? 3'd2 : (c < 21) ? 3'd1 :
                (c < 29) ? 3'd2 : (c < 33) ? 3'd3 : 3'd4;
      exp_sys = (c < 29) ? 3'b111 : (c < 31) ? 3'b110 : (c < 33) ? 3'b100 : 3'b000;
      checks++;
      if ({state_dbg, sys_rst} !== {exp_st, exp_sys}) begin
        failures++;
        $display("FAIL glitch c=%0d: state=%0d sys=%b required state=%0d sys=%b",
                 c, state_dbg, sys_rst, exp_st, exp_sys);
      end
      tick();
    end
    checks++;
    if (lock_lost_cnt !== 8'd0) begin
      failures++;
      $display("FAIL glitch_lost: got %0d required 0", lock_lost_cnt);
    end
  endtask

  task automatic test_timeout();
    logic       exp_pll;
    logic [7:0] exp_retry;
    logic       exp_err;
    do_reset();
    for (int c = 0; c <= 170; c++) begin
      exp_pll   = ((c % 54) < 4);
      exp_retry = 8'(c / 54);
      exp_err   = (c >= 54);
      checks++;
      if ({pll_rst, retry_cnt, timeout_err} !== {exp_pll, exp_retry, exp_err}) begin
        failures++;
        $display("FAIL timeout c=%0d: pll=%b retry=%0d err=%b required %b/%0d/%b",
                 c, pll_rst, retry_cnt, timeout_err, exp_pll, exp_retry, exp_err);
      end
      tick();
    end
  endtask

  task automatic test_loss_in_run();
    logic [7:0] exp_lost;
    locked_in = 1'b1;
    wait_ready(100);
    checks++;
    if (retry_cnt !== 8'd3 || timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL sticky_err: retry=%0d err=%b required 3/1", retry_cnt, timeout_err);
    end
    locked_in = 1'b0;
    tick();
    tick();
    checks++;
    if ({sys_rst, ready} !== 4'b000_1) begin
      failures++;
      $display("FAIL loss_latency: sys/ready=%b required 0001 two cycles after drop", {sys_rst, ready});
    end
    tick();
    checks++;
    if ({sys_rst, ready, state_dbg} !== {3'b111, 1'b0, 3'd0} || lock_lost_cnt !== 8'd1) begin
      failures++;
      $display("FAIL loss_in_run: sys=%b ready=%b state=%0d lost=%0d required 111/0/0/1",
               sys_rst, ready, state_dbg, lock_lost_cnt);
    end
    for (int n = 2; n <= 300; n++) begin
      locked_in = 1'b1;
      wait_ready(100);
      locked_in = 1'b0;
      tick();
      tick();
      tick();
      exp_lost = (n > 255) ? 8'd255 : 8'(n);
      if (n == 254 || n == 255 || n == 256 || n == 300) begin
        checks++;
        if (lock_lost_cnt !== exp_lost) begin
          failures++;
          $display("FAIL lost_sat n=%0d: got %0d required %0d", n, lock_lost_cnt, exp_lost);
        end
      end
    end
  endtask

  task automatic test_soft_rst();
    logic [4:0] exp;
    locked_in = 1'b1;
    wait_ready(100);
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      exp[4]   = (k <= 4);
      exp[3:1] = (k < 14) ? 3'b111 : (k < 16) ? 3'b110 : (k < 18) ? 3'b100 : 3'b000;
      exp[0]   = (k >= 18);
      checks++;
      if ({pll_rst, sys_rst, ready} !== exp) begin
        failures++;
        $display("FAIL soft_seq k=%0d: pll/sys/ready=%b required %b", k, {pll_rst, sys_rst, ready}, exp);
      end
      tick();
    end
    checks++;
    if (lock_lost_cnt !== 8'd255 || retry_cnt !== 8'd3) begin
      failures++;
      $display("FAIL soft_counters: lost=%0d retry=%0d required 255/3", lock_lost_cnt, retry_cnt);
    end
    // Second pulse lands while PLL_RST is already running.
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    tick();
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    for (int k = 3; k <= 17; k++) begin
      if (k <= 7) begin
        checks++;
        if (pll_rst !== (k <= 6)) begin
          failures++;
          $display("FAIL soft_in_pll_rst k=%0d: pll_rst=%b required %b", k, pll_rst, (k <= 6));
        end
      end
      if (k < 17) tick();
    end
  endtask

  task automatic test_async_rst();
    checks++;
    if (state_dbg !== 3'd3 || sys_rst !== 3'b110) begin
      failures++;
      $display("FAIL pre_async: state=%0d sys=%b required 3/110", state_dbg, sys_rst);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({pll_rst, sys_rst, ready, timeout_err, state_dbg} !== {1'b1, 3'b111, 1'b0, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL async_rst: pll=%b sys=%b ready=%b err=%b state=%0d required 1/111/0/0/0",
               pll_rst, sys_rst, ready, timeout_err, state_dbg);
    end
    checks++;
    if ({lock_lost_cnt, retry_cnt} !== 16'h0000) begin
      failures++;
      $display("FAIL async_counters: lost=%0d retry=%0d required 0/0", lock_lost_cnt, retry_cnt);
    end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_glitch();
    test_timeout();
    test_loss_in_run();
    test_soft_rst();
    test_async_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
